// File: rtl/stream_conv2d.sv
// Streaming K_DIM x K_DIM x IMG_CH convolution over a raster, channel-interleaved pixel stream.
// One sequential MAC per window. Define CONV_RELU_EN to clamp negative results to zero.
`timescale 1ns/1ps
module stream_conv2d #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WGT_W   = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned K_DIM   = 2,
  parameter int unsigned IMG_DIM = 4,
  parameter int unsigned IMG_CH  = 3,
  parameter int unsigned STRIDE  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_W-1:0]                      in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [K_DIM*K_DIM*IMG_CH*WGT_W-1:0]    weights,
  output logic [ACC_W-1:0]                       out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last
);
  localparam int unsigned OUT_DIM  = (IMG_DIM - K_DIM) / STRIDE + 1;
  localparam int unsigned TAPS     = K_DIM * K_DIM * IMG_CH;
  localparam int unsigned PROD_W   = WGT_W + DATA_W + 1;
  localparam int unsigned DEPTH    = K_DIM * IMG_DIM * IMG_CH;
  localparam int unsigned CH_W     = (IMG_CH > 1) ? $clog2(IMG_CH) : 1;
  localparam int unsigned POS_W    = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int unsigned KW       = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int unsigned TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WIDX_W   = $clog2(TAPS * WGT_W);
  localparam int unsigned LAST_POS = (OUT_DIM - 1) * STRIDE + K_DIM - 1;

  typedef enum logic [1:0] {ACCEPT, MAC, OUT} state_t;

  state_t                   state;
  logic [CH_W-1:0]          ch;
  logic [POS_W-1:0]         col;
  logic [POS_W-1:0]         row;
  logic [KW-1:0]            lrow;
  logic [TAP_W-1:0]         tap;
  logic [KW-1:0]            kx;
  logic [CH_W-1:0]          kc;
  logic [KW-1:0]            brow;
  logic [POS_W-1:0]         left;
  logic                     last;
  logic signed [ACC_W-1:0]  acc;

  logic [DATA_W-1:0]        lbuf [DEPTH];
  logic [ADDR_W-1:0]        wr_addr;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     accept;
  logic                     trigger;

  logic signed [WGT_W-1:0]  wgt;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  result;

  // True when position p is the bottom/right edge of a stride-aligned window.
  function automatic logic win_pos(input logic [POS_W-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int unsigned o = 0; o < OUT_DIM; o++) begin
      if (p == POS_W'(o * STRIDE + K_DIM - 1)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign accept  = in_valid && in_ready;
  assign trigger = accept && (ch == CH_W'(IMG_CH - 1)) && win_pos(row) && win_pos(col);
  assign wr_addr = ADDR_W'((32'(lrow) * IMG_DIM + 32'(col)) * IMG_CH + 32'(ch));
  assign rd_addr = ADDR_W'((32'(brow) * IMG_DIM + 32'(left) + 32'(kx)) * IMG_CH + 32'(kc));

  // One tap: signed weight times zero-extended pixel, wrapping accumulate.
  always_comb begin
    wgt      = $signed(weights[WIDX_W'(32'(tap) * WGT_W) +: WGT_W]);
    prod     = PROD_W'(wgt) * PROD_W'($signed({1'b0, lbuf[rd_addr]}));
    acc_next = acc + ACC_W'(prod);
    result   = acc_next;
`ifdef CONV_RELU_EN
    if (acc_next[ACC_W-1]) result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) lbuf[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCEPT;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      ch        <= '0;
      col       <= '0;
      row       <= '0;
      lrow      <= '0;
      tap       <= '0;
      kx        <= '0;
      kc        <= '0;
      brow      <= '0;
      left      <= '0;
      last      <= 1'b0;
      acc       <= '0;
    end else begin
      // Raster position of the next sample; lrow is row mod K_DIM.
      if (accept) begin
        if (ch == CH_W'(IMG_CH - 1)) begin
          ch <= '0;
          if (col == POS_W'(IMG_DIM - 1)) begin
            col <= '0;
            if (row == POS_W'(IMG_DIM - 1)) begin
              row  <= '0;
              lrow <= '0;
            end else begin
              row  <= row + 1'b1;
              lrow <= (lrow == KW'(K_DIM - 1)) ? '0 : lrow + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          ch <= ch + 1'b1;
        end
      end

      case (state)
        ACCEPT: begin
          in_ready <= 1'b1;
          if (trigger) begin
            state    <= MAC;
            in_ready <= 1'b0;
            acc      <= '0;
            tap      <= '0;
            kx       <= '0;
            kc       <= '0;
            // Window top row (row-K_DIM+1) maps to buffer row (lrow+1) mod K_DIM.
            brow     <= (lrow == KW'(K_DIM - 1)) ? '0 : lrow + 1'b1;
            left     <= col - POS_W'(K_DIM - 1);
            last     <= (row == POS_W'(LAST_POS)) && (col == POS_W'(LAST_POS));
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          if (kc == CH_W'(IMG_CH - 1)) begin
            kc <= '0;
            if (kx == KW'(K_DIM - 1)) begin
              kx   <= '0;
              brow <= (brow == KW'(K_DIM - 1)) ? '0 : brow + 1'b1;
            end else begin
              kx <= kx + 1'b1;
            end
          end else begin
            kc <= kc + 1'b1;
          end
          if (tap == TAP_W'(TAPS - 1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= last;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACCEPT;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end
endmodule
